// File: rtl/rr_grant_scheduler_pkg.sv
// Shared types and constants for the round-robin grant scheduler.
package ppe_pkg;

  // Grant sequencing states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OFFER = 2'd1,
    ST_BUSY  = 2'd2
  } state_e;

  // Arbitration mode encodings for cfg_mode
  localparam logic MODE_RR    = 1'b0;
  localparam logic MODE_FIXED = 1'b1;

  // Hold counter width: clog2(max_hold+1), kept at least 1 bit so the
  // unlimited (max_hold == 0) build still has a counter to saturate.
  function automatic int hold_w(input int max_hold);
    return (max_hold == 0) ? 1 : $clog2(max_hold + 1);
  endfunction

endpackage

// File: rtl/rr_grant_scheduler_encoder.sv
// Highest-index-wins priority encoder; idx is 0 when vec is empty.
module encoder #(
  parameter int WIDTH = 8,
  parameter int LOG_W = 3
) (
  input  logic [WIDTH-1:0] vec,
  output logic [LOG_W-1:0] idx
);

  // Later (higher) set bits overwrite earlier ones, so the top bit wins
  always_comb begin
    idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (vec[i]) idx = LOG_W'(i);
    end
  end

endmodule

// File: rtl/rr_grant_scheduler.sv
// Round-robin / fixed-priority scheduler for one shared resource.
// Winner is picked in IDLE, offered with gnt_valid, held in BUSY until the
// holder drops its request or the hold limit preempts it.
module rr_grant_scheduler
  import ppe_pkg::*;
#(
  parameter int N        = 8,
  parameter int LOG_N    = 3,
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic             cfg_mode,
  input  logic             cfg_ptr_we,
  input  logic [LOG_N-1:0] cfg_ptr,
  input  logic             gnt_ready,
  output logic             gnt_valid,
  output logic [LOG_N-1:0] gnt_idx,
  output logic [N-1:0]     gnt_onehot,
  output logic             busy,
  output logic [LOG_N-1:0] ptr
);

  localparam int HCW = hold_w(MAX_HOLD);
  localparam logic [HCW-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : HCW'(MAX_HOLD - 1);

  state_e             state_q, state_d;
  logic               mode_q, mode_d;
  logic [HCW-1:0]     hold_cnt, hold_d;
  logic [LOG_N-1:0]   idx_d, ptr_d;
  logic [N-1:0]       ptr_mask, masked;
  logic [LOG_N-1:0]   idx_m, idx_r, winner;
  logic               req_cur, preempt, hold_sat;

  // Requests strictly below the pointer get first pick in round-robin
  assign ptr_mask = (N'(1) << ptr) - N'(1);
  assign masked   = req & ptr_mask;

  encoder #(.WIDTH(N), .LOG_W(LOG_N)) u_enc_m (.vec(masked), .idx(idx_m));
  encoder #(.WIDTH(N), .LOG_W(LOG_N)) u_enc_r (.vec(req),    .idx(idx_r));

  // Empty masked set wraps the search back to the top index
  assign winner   = (cfg_mode == MODE_RR && |masked) ? idx_m : idx_r;
  assign req_cur  = req[gnt_idx];
  assign preempt  = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);
  assign hold_sat = &hold_cnt;

  // Next-state, grant index, hold counter and pointer update
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    hold_d  = hold_cnt;
    idx_d   = gnt_idx;
    ptr_d   = ptr;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          state_d = ST_OFFER;
          idx_d   = winner;
          mode_d  = cfg_mode;
        end
      end
      ST_OFFER: begin
        // A withdrawn request beats a same-cycle accept
        if (!req_cur) begin
          state_d = ST_IDLE;
        end else if (gnt_ready) begin
          state_d = ST_BUSY;
          hold_d  = '0;
          if (mode_q == MODE_RR) ptr_d = gnt_idx;
        end
      end
      ST_BUSY: begin
        if (!hold_sat) hold_d = hold_cnt + HCW'(1);
        if (!req_cur || preempt) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Software pointer write overrides the acceptance update
    if (cfg_ptr_we) ptr_d = cfg_ptr;
  end

  // State and registered outputs; reset drops any grant immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      mode_q     <= MODE_RR;
      hold_cnt   <= '0;
      gnt_idx    <= '0;
      ptr        <= '0;
      gnt_valid  <= 1'b0;
      busy       <= 1'b0;
      gnt_onehot <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      hold_cnt   <= hold_d;
      gnt_idx    <= idx_d;
      ptr        <= ptr_d;
      gnt_valid  <= (state_d == ST_OFFER);
      busy       <= (state_d == ST_BUSY);
      gnt_onehot <= (state_d == ST_BUSY) ? (N'(1) << idx_d) : '0;
    end
  end

endmodule
